// File: rtl/token_buf_ctrl_pkg.sv
// Shared token codes, key indices and FSM state encoding for the token buffer controller.
package token_buf_ctrl_pkg;

  localparam logic [7:0] OP_ADD = 8'hA0;
  localparam logic [7:0] OP_SUB = 8'hA1;
  localparam logic [7:0] OP_MUL = 8'hA2;
  localparam logic [7:0] OP_DIV = 8'hA3;
  localparam logic [7:0] OP_LB  = 8'hA4;
  localparam logic [7:0] OP_RB  = 8'hA5;

  localparam int unsigned KEY_N   = 5;
  localparam int unsigned K_RIGHT = 0;
  localparam int unsigned K_LEFT  = 1;
  localparam int unsigned K_INS   = 2;
  localparam int unsigned K_DEL   = 3;
  localparam int unsigned K_EVAL  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INS_SHIFT,
    S_INS_WRITE,
    S_DEL_SHIFT,
    S_STREAM
  } state_t;

endpackage

// File: rtl/token_buf_ctrl_rise_det.sv
// Rising-edge detector for N key levels; keys held across reset stay masked until released.
module rise_det #(
  parameter int unsigned N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] i_lvl,
  output logic [N-1:0] o_rise
);

  logic [N-1:0] r_prev;
  logic [N-1:0] r_hold;

  // r_hold latches keys that are down during reset and clears each bit on release.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev <= '0;
      r_hold <= i_lvl;
    end else begin
      r_prev <= i_lvl;
      r_hold <= r_hold & i_lvl;
    end
  end

  assign o_rise = i_lvl & ~r_prev & ~r_hold;

endmodule

// File: rtl/token_buf_ctrl.sv
// Keyboard token line buffer: cursor editing with one-per-cycle shifts and a ready/valid token stream.
module token_buf_ctrl
  import token_buf_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         dataIn,
  input  logic                     insert,
  input  logic                     del_pulse,
  input  logic                     ptrLeft_pulse,
  input  logic                     ptrRight_pulse,
  input  logic                     eval_pulse,
  input  logic                     tok_ready,
  output logic [WIDTH-1:0]         tok_data,
  output logic                     tok_valid,
  output logic                     tok_last,
  output logic                     eval_done,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   cursor,
  output logic                     busy,
  output logic                     err,
  output logic                     drop
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  state_t           r_state, w_state_nx;
  logic [AW:0]      r_count, w_count_nx;
  logic [AW:0]      r_cursor, w_cursor_nx;
  logic [AW:0]      r_idx, w_idx_nx;
  logic [WIDTH-1:0] r_tok, w_tok_nx;
  logic             r_err, w_err_nx;
  logic             r_drop, w_drop_nx;
  logic             r_done, w_done_nx;

  logic [WIDTH-1:0] r_buf [DEPTH];
  logic             w_we;
  logic [AW-1:0]    w_waddr;
  logic [WIDTH-1:0] w_wdata;
  logic [AW-1:0]    w_ia;

  logic [KEY_N-1:0] w_lvl;
  logic [KEY_N-1:0] w_rise;

  assign w_lvl = {eval_pulse, del_pulse, insert, ptrLeft_pulse, ptrRight_pulse};

  rise_det #(.N(KEY_N)) u_rise_det (
    .clk   (clock),
    .rst_n (reset),
    .i_lvl (w_lvl),
    .o_rise(w_rise)
  );

  assign w_ia = r_idx[AW-1:0];

  always_comb begin
    w_state_nx  = r_state;
    w_count_nx  = r_count;
    w_cursor_nx = r_cursor;
    w_idx_nx    = r_idx;
    w_tok_nx    = r_tok;
    w_err_nx    = 1'b0;
    w_drop_nx   = 1'b0;
    w_done_nx   = 1'b0;
    w_we        = 1'b0;
    w_waddr     = w_ia;
    w_wdata     = r_buf[w_ia];

    unique case (r_state)
      S_IDLE: begin
        if (w_rise[K_EVAL]) begin
          if (r_count == '0) begin
            w_done_nx = 1'b1;
          end else begin
            w_state_nx = S_STREAM;
            w_idx_nx   = '0;
          end
        end else if (w_rise[K_DEL]) begin
          if (r_cursor == '0) begin
            w_err_nx = 1'b1;
          end else begin
            w_state_nx = S_DEL_SHIFT;
            w_idx_nx   = r_cursor;
          end
        end else if (w_rise[K_INS]) begin
          if (r_count == DEPTH_C) begin
            w_err_nx = 1'b1;
          end else begin
            w_tok_nx = dataIn;
            if (r_cursor == r_count) begin
              w_state_nx = S_INS_WRITE;
            end else begin
              w_state_nx = S_INS_SHIFT;
              w_idx_nx   = r_count - ONE;
            end
          end
        end else if (w_rise[K_LEFT]) begin
          if (r_cursor == '0) w_err_nx = 1'b1;
          else                w_cursor_nx = r_cursor - ONE;
        end else if (w_rise[K_RIGHT]) begin
          if (r_cursor == r_count) w_err_nx = 1'b1;
          else                     w_cursor_nx = r_cursor + ONE;
        end
      end

      // Shift walks downward from the last token so each cycle needs only one write.
      S_INS_SHIFT: begin
        w_we    = 1'b1;
        w_waddr = w_ia + AW'(1);
        w_wdata = r_buf[w_ia];
        if (r_idx == r_cursor) w_state_nx = S_INS_WRITE;
        else                   w_idx_nx   = r_idx - ONE;
      end

      S_INS_WRITE: begin
        w_we        = 1'b1;
        w_waddr     = r_cursor[AW-1:0];
        w_wdata     = r_tok;
        w_count_nx  = r_count + ONE;
        w_cursor_nx = r_cursor + ONE;
        w_state_nx  = S_IDLE;
      end

      // With the cursor at the end there is nothing to move, but one cycle is still spent.
      S_DEL_SHIFT: begin
        if (r_idx < r_count) begin
          w_we    = 1'b1;
          w_waddr = w_ia - AW'(1);
          w_wdata = r_buf[w_ia];
        end
        if ((r_idx + ONE) >= r_count) begin
          w_count_nx  = r_count - ONE;
          w_cursor_nx = r_cursor - ONE;
          w_state_nx  = S_IDLE;
        end else begin
          w_idx_nx = r_idx + ONE;
        end
      end

      S_STREAM: begin
        if (tok_ready) begin
          if (r_idx == r_count - ONE) begin
            w_state_nx = S_IDLE;
            w_done_nx  = 1'b1;
          end else begin
            w_idx_nx = r_idx + ONE;
          end
        end
      end

      default: w_state_nx = S_IDLE;
    endcase

    if (r_state != S_IDLE && w_rise != '0) w_drop_nx = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_cursor <= '0;
      r_idx    <= '0;
      r_tok    <= '0;
      r_err    <= 1'b0;
      r_drop   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_count  <= w_count_nx;
      r_cursor <= w_cursor_nx;
      r_idx    <= w_idx_nx;
      r_tok    <= w_tok_nx;
      r_err    <= w_err_nx;
      r_drop   <= w_drop_nx;
      r_done   <= w_done_nx;
    end
  end

  // Buffer is not cleared by reset, but a shift in flight must not land on the reset edge.
  always_ff @(posedge clock) begin
    if (reset && w_we) r_buf[w_waddr] <= w_wdata;
  end

  assign tok_valid = (r_state == S_STREAM);
  assign tok_last  = tok_valid && (r_idx == r_count - ONE);
  assign tok_data  = r_buf[w_ia];
  assign rd_data   = r_buf[rd_addr];
  assign count     = r_count;
  assign cursor    = r_cursor;
  assign busy      = (r_state != S_IDLE);
  assign err       = r_err;
  assign drop      = r_drop;
  assign eval_done = r_done;

endmodule

// File: tb/tb_token_buf_ctrl.sv
// Randomized and directed bench for token_buf_ctrl against a queue-based line-buffer model.
module tb_token_buf_ctrl;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = $clog2(DEPTH);

  logic             clock = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] dataIn;
  logic             insert, del_pulse, ptrLeft_pulse, ptrRight_pulse, eval_pulse;
  logic             tok_ready;
  logic [WIDTH-1:0] tok_data;
  logic             tok_valid, tok_last, eval_done;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;
  logic [AW:0]      count, cursor;
  logic             busy, err, drop;

  int n_cmp = 0;
  int n_err = 0;

  logic [WIDTH-1:0] q[$];
  int               cur = 0;

  token_buf_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .dataIn(dataIn), .insert(insert),
    .del_pulse(del_pulse), .ptrLeft_pulse(ptrLeft_pulse),
    .ptrRight_pulse(ptrRight_pulse), .eval_pulse(eval_pulse),
    .tok_ready(tok_ready), .tok_data(tok_data), .tok_valid(tok_valid),
    .tok_last(tok_last), .eval_done(eval_done), .rd_addr(rd_addr),
    .rd_data(rd_data), .count(count), .cursor(cursor), .busy(busy),
    .err(err), .drop(drop)
  );

  always #10 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_key(input int k, input logic v);
    case (k)
      0: insert = v;
      1: del_pulse = v;
      2: ptrLeft_pulse = v;
      3: ptrRight_pulse = v;
      default: eval_pulse = v;
    endcase
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 32'(count), 32'(q.size()));
    chk({tag, "_cursor"}, 32'(cursor), 32'(cur));
    for (int i = 0; i < q.size(); i++) begin
      rd_addr = AW'(i);
      #1;
      chk({tag, "_buf"}, 32'(rd_data), 32'(q[i]));
    end
  endtask

  task automatic do_key(input int k, input logic [WIDTH-1:0] d, input bit e, input int lat_exp, input string tag);
    int lat;
    dataIn = d;
    set_key(k, 1'b1);
    tick();
    set_key(k, 1'b0);
    dataIn = WIDTH'($urandom);
    chk({tag, "_err"}, 32'(err), 32'(e));
    chk({tag, "_drop"}, 32'(drop), 32'd0);
    lat = 0;
    while (busy === 1'b1 && lat < 64) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(lat_exp));
    tick();
    chk({tag, "_errpulse"}, 32'(err), 32'd0);
    check_state(tag);
  endtask

  // Model: q is the token line, cur the insertion point; shifts cost one cycle per moved token.
  task automatic do_cmd(input int k, input logic [WIDTH-1:0] d, input string tag);
    bit e = 1'b0;
    int lat = 0;
    int sz = q.size();
    case (k)
      0: if (sz == DEPTH) e = 1'b1;
         else begin lat = sz - cur + 1; q.insert(cur, d); cur++; end
      1: if (cur == 0) e = 1'b1;
         else begin lat = (sz - cur > 1) ? sz - cur : 1; q.delete(cur - 1); cur--; end
      2: if (cur == 0) e = 1'b1; else cur--;
      default: if (cur == sz) e = 1'b1; else cur++;
    endcase
    do_key(k, d, e, lat, tag);
  endtask

  task automatic run_eval(input bit directed, input string tag);
    int n = q.size();
    int k = 0;
    int cyc = 0;
    tok_ready = 1'b0;
    eval_pulse = 1'b1;
    tick();
    eval_pulse = 1'b0;
    if (n == 0) begin
      chk({tag, "_empty_done"}, 32'(eval_done), 32'd1);
      chk({tag, "_empty_valid"}, 32'(tok_valid), 32'd0);
      chk({tag, "_empty_busy"}, 32'(busy), 32'd0);
    end else begin
      while (k < n && cyc < 200) begin
        chk({tag, "_done_early"}, 32'(eval_done), 32'd0);
        chk({tag, "_valid"}, 32'(tok_valid), 32'd1);
        chk({tag, "_data"}, 32'(tok_data), 32'(q[k]));
        chk({tag, "_last"}, 32'(tok_last), 32'(k == n - 1));
        if (directed) begin
          if (cyc == 0) del_pulse = 1'b1;
          if (cyc == 1) begin
            chk({tag, "_drop"}, 32'(drop), 32'd1);
            del_pulse = 1'b0;
          end
          if (cyc == 2) chk({tag, "_drop_clr"}, 32'(drop), 32'd0);
          tok_ready = (cyc == 1 || cyc == 2) ? 1'b0 : 1'b1;
        end else begin
          tok_ready = ($urandom_range(0, 2) != 0);
        end
        tick();
        if (tok_ready) k++;
        cyc++;
      end
      chk({tag, "_handshakes"}, 32'(k), 32'(n));
      chk({tag, "_done"}, 32'(eval_done), 32'd1);
      chk({tag, "_valid_end"}, 32'(tok_valid), 32'd0);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    end
    tok_ready = 1'b0;
    del_pulse = 1'b0;
    tick();
    chk({tag, "_done_once"}, 32'(eval_done), 32'd0);
    check_state(tag);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    q.delete();
    cur = 0;
  endtask

  function automatic logic [WIDTH-1:0] rnd_tok();
    int v = $urandom_range(0, 15);
    return (v < 10) ? WIDTH'(v) : WIDTH'(8'hA0 + (v - 10) % 6);
  endfunction

  initial begin
    int r;
    reset = 1'b0; dataIn = '0; tok_ready = 1'b0; rd_addr = '0;
    insert = 1'b0; del_pulse = 1'b0; ptrLeft_pulse = 1'b0;
    ptrRight_pulse = 1'b0; eval_pulse = 1'b0;
    tick();
    tick();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_cursor", 32'(cursor), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(tok_valid), 32'd0);
    chk("rst_last", 32'(tok_last), 32'd0);
    chk("rst_done", 32'(eval_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    reset = 1'b1;
    tick();

    do_cmd(0, 8'h01, "ins_end1");
    do_cmd(0, 8'h02, "ins_end2");
    do_cmd(0, 8'hA0, "ins_end3");

    do_reset();
    do_cmd(0, 8'h01, "mk1");
    do_cmd(0, 8'h02, "mk2");
    do_cmd(0, 8'h03, "mk3");
    for (int i = 0; i < 3; i++) do_cmd(2, 8'h00, "left");
    do_cmd(3, 8'h00, "right");
    do_cmd(0, 8'h09, "ins_mid");
    do_cmd(1, 8'h00, "del_mid");
    do_cmd(2, 8'h00, "left0");
    do_cmd(1, 8'h00, "del_at0");

    do_reset();
    for (int i = 0; i < DEPTH; i++) do_cmd(0, rnd_tok(), "fill");
    do_cmd(0, 8'h07, "ins_full");
    do_cmd(3, 8'h00, "right_end");
    run_eval(1'b0, "eval_full");

    do_reset();
    run_eval(1'b0, "eval_empty");
    do_cmd(0, 8'h05, "ev1");
    do_cmd(0, 8'hA2, "ev2");
    do_cmd(0, 8'h07, "ev3");
    run_eval(1'b1, "eval_stall");

    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 11);
      if (r < 5)       do_cmd(0, rnd_tok(), "rnd_ins");
      else if (r < 7)  do_cmd(1, 8'h00, "rnd_del");
      else if (r < 9)  do_cmd(2, 8'h00, "rnd_left");
      else if (r < 11) do_cmd(3, 8'h00, "rnd_right");
      else             run_eval(1'b0, "rnd_eval");
    end

    do_reset();
    do_cmd(0, 8'h11, "pre1");
    do_cmd(0, 8'h12, "pre2");
    do_cmd(0, 8'h13, "pre3");
    for (int i = 0; i < 3; i++) do_cmd(2, 8'h00, "pre_left");
    dataIn = 8'h44;
    insert = 1'b1;
    tick();
    chk("mid_shift_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    q.delete();
    cur = 0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    chk("abort_cursor", 32'(cursor), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("held_busy", 32'(busy), 32'd0);
      chk("held_count", 32'(count), 32'd0);
    end
    insert = 1'b0;
    tick();
    tick();
    do_cmd(0, 8'h55, "after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
